// File: rtl/collision_scanner.sv
// collision_scanner: per-frame ball/object collision probes with a registered report once per frame.
// Optional corner probes are enabled by defining COLLISION_CORNER_EN.
module collision_scanner #(
    parameter int NUM_OBJ     = 3,
    parameter int BALL_SIZE   = 8,
    parameter int CNT_W       = 10,
    parameter int REPORT_LINE = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   h_cnt,
    input  logic [CNT_W-1:0]   v_cnt,
    input  logic               valid,
    input  logic [NUM_OBJ-1:0] obj_pix,
    input  logic [CNT_W-1:0]   ball_x,
    input  logic [CNT_W-1:0]   ball_y,
    output logic               col_x1,
    output logic               col_x2,
    output logic               col_y1,
    output logic               col_y2,
    output logic               flip_x,
    output logic               flip_y,
    output logic [NUM_OBJ-1:0] hit_mask,
    output logic               report_valid,
    output logic [3:0]         col_corner
);
    localparam int H  = BALL_SIZE / 2;
    localparam int PW = CNT_W + 1;

    typedef enum logic [1:0] {ARMED, SCAN, REPORT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   sx, sy;
    logic               bnd_q, bnd_cond, boundary, act, any;
    logic [3:0]         e, acc_e;
    logic [NUM_OBJ-1:0] acc_m;
    logic [PW-1:0]      hx, vy, x0, xh, xb, y0, yh, yb;

    assign bnd_cond = v_cnt == CNT_W'(REPORT_LINE) && h_cnt == '0;
    assign boundary = bnd_cond && !bnd_q;
    assign act      = valid && |obj_pix;

    // Probe coordinates carry an extra bit so an overflowing probe can never equal a counter value.
    assign hx = {1'b0, h_cnt};
    assign vy = {1'b0, v_cnt};
    assign x0 = {1'b0, sx};
    assign y0 = {1'b0, sy};
    assign xh = x0 + PW'(H);
    assign xb = x0 + PW'(BALL_SIZE);
    assign yh = y0 + PW'(H);
    assign yb = y0 + PW'(BALL_SIZE);

    assign e = {4{act}} & {hx == xh && vy == yb, hx == xh && vy == y0,
                           hx == xb && vy == yh, hx == x0 && vy == yh};

`ifdef COLLISION_CORNER_EN
    logic [3:0] c, acc_c;
    assign c   = {4{act}} & {hx == xb && vy == yb, hx == x0 && vy == yb,
                             hx == xb && vy == y0, hx == x0 && vy == y0};
    assign any = |{e, c};
`else
    assign any        = |e;
    assign col_corner = 4'b0;
`endif

    assign flip_x = col_x1 ^ col_x2;
    assign flip_y = col_y1 ^ col_y2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ARMED;
            bnd_q        <= 1'b0;
            sx           <= '0;
            sy           <= '0;
            acc_e        <= '0;
            acc_m        <= '0;
            {col_y2, col_y1, col_x2, col_x1} <= '0;
            hit_mask     <= '0;
            report_valid <= 1'b0;
`ifdef COLLISION_CORNER_EN
            acc_c        <= '0;
            col_corner   <= '0;
`endif
        end else begin
            bnd_q        <= bnd_cond;
            report_valid <= 1'b0;
            case (state)
                ARMED: if (boundary) begin
                    sx    <= ball_x;
                    sy    <= ball_y;
                    acc_e <= '0;
                    acc_m <= '0;
`ifdef COLLISION_CORNER_EN
                    acc_c <= '0;
`endif
                    state <= SCAN;
                end
                SCAN: if (boundary) begin
                    {col_y2, col_y1, col_x2, col_x1} <= acc_e;
                    hit_mask     <= acc_m;
                    report_valid <= 1'b1;
`ifdef COLLISION_CORNER_EN
                    col_corner   <= acc_c;
`endif
                    state        <= REPORT;
                end else begin
                    acc_e <= acc_e | e;
                    acc_m <= acc_m | (any ? obj_pix : '0);
`ifdef COLLISION_CORNER_EN
                    acc_c <= acc_c | c;
`endif
                end
                default: begin
                    // Hits seen while reporting belong to the frame that starts now.
                    sx    <= ball_x;
                    sy    <= ball_y;
                    acc_e <= e;
                    acc_m <= any ? obj_pix : '0;
`ifdef COLLISION_CORNER_EN
                    acc_c <= c;
`endif
                    state <= SCAN;
                end
            endcase
        end
    end
endmodule
